// File: rtl/sigmoid_recip.sv
// Reciprocal stage of the sigmoid datapath: y = 1/(1+z) via a bit-serial restoring divider.
// Optional round-to-nearest of the quotient is enabled by defining SIGMOID_RECIP_ROUND_EN.
module sigmoid_recip #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  input  logic              in_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y
);

  localparam int unsigned QW = FRAC_W + 1;
  localparam int unsigned DW = FRAC_W + 2;
  localparam int unsigned IW = $clog2(QW + 1);

  localparam logic [DW-1:0]     ONE_D   = DW'(1) << FRAC_W;
  localparam logic [QW-1:0]     ONE_Q   = QW'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] ONE_Z   = DATA_W'(1) << FRAC_W;
  localparam logic [DW-1:0]     R_START = DW'(1) << (FRAC_W - 1);
  localparam logic [IW-1:0]     I_START = IW'(FRAC_W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] d;
  logic [DW-1:0] r;
  logic [QW-1:0] q;
  logic [IW-1:0] i;
  logic          neg;

  logic [QW-1:0]     zc;
  logic [DW:0]       r_sh;
  logic              ge;
  logic [DW-1:0]     r_nxt;
  logic [QW-1:0]     q_nxt;
  logic [QW-1:0]     q_fin;
  logic [DATA_W-1:0] y;

  // R < d always holds, so the shifted remainder never needs more than DW+1 bits
  always_comb begin
    zc    = (in_z > ONE_Z) ? ONE_Q : in_z[QW-1:0];
    r_sh  = {r, 1'b0};
    ge    = (r_sh >= {1'b0, d});
    r_nxt = ge ? DW'(r_sh - {1'b0, d}) : r_sh[DW-1:0];
    q_nxt = q | (QW'(ge) << i);
    q_fin = q_nxt;
`ifdef SIGMOID_RECIP_ROUND_EN
    if (({r_nxt, 1'b0} >= {1'b0, d}) && (q_nxt != ONE_Q)) begin
      q_fin = q_nxt + 1'b1;
    end
`endif
    y = neg ? DATA_W'(ONE_Q - q_fin) : DATA_W'(q_fin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (i == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is held low during reset, independent of the registered state
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= '0;
      r     <= '0;
      q     <= '0;
      i     <= '0;
      neg   <= 1'b0;
      out_y <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            d   <= {1'b0, zc} + ONE_D;
            r   <= R_START;
            q   <= '0;
            i   <= I_START;
            neg <= in_neg;
          end
        end
        BUSY: begin
          r <= r_nxt;
          q <= q_nxt;
          i <= i - 1'b1;
          if (i == '0) begin
            out_y <= y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sigmoid_recip.md
# sigmoid_recip

Sequential reciprocal stage that sits directly downstream of the `exp` block in the sigmoid datapath. It consumes z = e^(-|x|) in unsigned Q4.16 and produces sigmoid(x) = 1/(1+z) in Q4.16. For negative x it applies the symmetry correction 1 − 1/(1+z). The divide is a bit-serial restoring divider behind a valid/ready handshake on both sides.

## Interface
- `DATA_W`, default 20: width of `in_z` and `out_y`.
- `FRAC_W`, default 16: fractional bits. Quotient iterations = FRAC_W+1 = 17.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `in_z`/`in_neg` valid.
- `in_ready`  out  1  stage can accept; high only in IDLE.
- `in_z`  in  20  e^(-|x|), Q4.16, expected range 0..65536.
- `in_neg`  in  1  sign of the original x; 1 means x < 0.
- `out_valid`  out  1  `out_y` valid.
- `out_ready`  in  1  downstream accepts `out_y`.
- `out_y`  out  20  sigmoid(x), Q4.16, range 0..65536.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, capture the inputs and move to BUSY.
  - Clamp: zc = min(`in_z`, 65536).
  - Divisor d = 65536 + zc, 18 bits, range 65536..131072.
  - Remainder R = 2^15 (18 bits). Quotient q = 0 (17 bits). Iteration counter i = 16 (5 bits). Latch `in_neg`.
- **BUSY:** one iteration per cycle.
  - R' = R<<1.
  - If R' ≥ d: R = R' − d and q[i] = 1. Otherwise R = R', q[i] = 0.
  - Decrement i. The iteration at i=0 is the last.
  - Result q = floor(2^32/d), range 32768..65536.
  - After the last iteration, compute y from q and the latched sign, load it into `out_y`, and move to DONE.
    - Positive x: y = q.
    - Negative x: y = 65536 − q.
- **DONE:**
  - `out_valid`=1. `out_y` is held stable.
  - `in_valid` is ignored.
  - On `out_ready`=1, go to IDLE and drop `out_valid`.
- **Arithmetic:**
  - All values are unsigned.
  - q never exceeds 65536, so 65536 − q never underflows.
  - Upper bits of `out_y` above bit 16 are always 0.
- **Boundaries:**
  - zc=0 gives q=65536, the only case with q[16]=1.
  - zc=65536 gives q=32768.
  - `in_z` > 65536 is treated as 65536. There is no error flag.
- **Reset:**
  - `rst` in any state, including mid-BUSY, aborts the operation with no output.
  - State goes to IDLE. `out_valid`=0, `out_y`=0, q=0, R=0, i=0.
  - `in_ready`=0 while `rst` is high and 1 in the first cycle after release.

## Timing
- Handshake on accept edge T. BUSY iterations occur on edges T+1..T+17. `out_valid` rises after edge T+17, so latency is 17 cycles.
- If `out_ready` is high when `out_valid` rises, the transfer completes at edge T+18. IDLE follows, and `in_ready`=1 in the cycle after T+18.
- Next accept no earlier than edge T+19. Peak throughput is 1 result per 19 cycles.
- There is no overlap between capture and output. `in_ready` is 0 throughout BUSY and DONE.
- `in_ready` and `out_valid` are decoded from state registers only. There is no combinational path from `out_ready` or `in_valid`.

## Configuration
- `SIGMOID_RECIP_ROUND_EN`
  - **Defined:** after the final iteration, if 2R ≥ d then q = q + 1, saturated at 65536. Rounding is applied before the negative-x correction. Latency is unchanged (17 cycles).
  - **Undefined:** q is truncated (floor). This is the default and the golden-model reference.

## Test plan
- **Zero input:** `in_z`=0, `in_neg`=0 → `out_y`=65536, `out_valid` exactly 17 cycles after accept. With `in_neg`=1 → `out_y`=0.
- **z = 1.0:** `in_z`=65536, `in_neg`=0 and then 1 → `out_y`=32768 both times. Also `in_z`=70000 → clamped, `out_y`=32768.
- **z = e^-1:** `in_z`=24109, `in_neg`=0 → `out_y`=47910 truncated, 47911 with `SIGMOID_RECIP_ROUND_EN`. With `in_neg`=1 → 17626 truncated, 17625 rounded.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid`, and pulse `in_valid` meanwhile.
  - `out_y` stays stable, `in_ready` stays 0, and the new input is not captured.
  - Release `out_ready`: `in_ready`=1 in the next cycle.
- **Reset mid-operation:** assert `rst` for 1 cycle at BUSY iteration 8.
  - `out_valid` never rises for that input. `out_y`=0, `in_ready`=1 after release.
  - A new accept of `in_z`=0 returns 65536 after 17 cycles.
- **Random sweep:** 1000 random `in_z` in 0..65536 with random `in_neg` and random `out_ready` stalls.
  - Every `out_y` equals floor(2^32/(65536+z)), or 65536 minus that value for `in_neg`=1.
  - No transaction is lost or duplicated.
